// File: rtl/inertial_read_ctrl_pkg.sv
// Shared definitions for the IMU read sequencer: state encoding and the fixed SPI command tables.
package inertial_pkg;

  typedef enum logic [2:0] {
    PWRUP   = 3'd0,
    INIT_WR = 3'd1,
    INIT_WT = 3'd2,
    IDLE    = 3'd3,
    RD_WR   = 3'd4,
    RD_WT   = 3'd5,
    DONE    = 3'd6
  } inert_state_t;

  // IMU register writes issued once after power-up, in this order.
  localparam logic [15:0] INIT_CMDS [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  // Register reads per data-ready: pitchL, pitchH, AZL, AZH.
  localparam logic [15:0] READ_CMDS [4] = '{16'hA400, 16'hA500, 16'hAC00, 16'hAD00};

  // Offsets applied by the downstream integrator; trimmed at bring-up.
  localparam logic signed [15:0] PTCH_RT_OFFSET = 16'sh0000;
  localparam logic signed [15:0] AZ_OFFSET      = 16'sh0000;

  function automatic logic is_wr_state(inert_state_t s);
    return (s == INIT_WR) || (s == RD_WR);
  endfunction

endpackage

// File: rtl/inertial_read_ctrl_if.sv
// Handshake between the IMU sequencer and the shared SPI master.
interface inertial_read_ctrl_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd_data;

  modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd_data);
  modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd_data);
endinterface

// File: rtl/inertial_read_ctrl.sv
// IMU sequencer: power-up wait, four config writes, then four byte reads per data-ready
// interrupt, presenting pitch rate and Z acceleration with a one-cycle valid pulse.
module inertial_read_ctrl
  import inertial_pkg::*;
#(
  parameter int PWRUP_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 INT,
  inertial_read_ctrl_if.master spi,
  output logic [15:0]          ptch_rt,
  output logic [15:0]          AZ,
  output logic                 vld
);

  inert_state_t          state_reg, state_next;
  logic [1:0]            idx_reg, idx_next;
  logic [PWRUP_BITS-1:0] pwr_cnt_reg;
  logic                  int_ff1_reg, int_ff2_reg;
  logic [7:0]            hold_reg  [4];
  logic [7:0]            hold_next [4];
  logic                  rd_capture;
  logic                  last_capture;
  logic                  unused_rd_hi;

  assign unused_rd_hi = ^spi.spi_rd_data[15:8];

  // INT is asynchronous to clk; only the second flop is ever observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_reg <= 1'b0;
      int_ff2_reg <= 1'b0;
    end else begin
      int_ff1_reg <= INT;
      int_ff2_reg <= int_ff1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwr_cnt_reg <= '0;
    else if (state_reg == PWRUP && !(&pwr_cnt_reg))
      pwr_cnt_reg <= pwr_cnt_reg + 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      PWRUP: begin
        if (&pwr_cnt_reg) begin
          state_next = INIT_WR;
          idx_next   = 2'd0;
        end
      end
      INIT_WR: state_next = INIT_WT;
      INIT_WT: begin
        if (spi.spi_done) begin
          if (idx_reg != 2'd3) begin
            idx_next   = idx_reg + 2'd1;
            state_next = INIT_WR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      IDLE: begin
        if (int_ff2_reg) begin
          state_next = RD_WR;
          idx_next   = 2'd0;
        end
      end
      RD_WR: state_next = RD_WT;
      RD_WT: begin
        if (spi.spi_done) begin
          if (idx_reg != 2'd3) begin
            idx_next   = idx_reg + 2'd1;
            state_next = RD_WR;
          end else begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= PWRUP;
      idx_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Command is a pure function of state and index, so it stays put for the whole transaction.
  assign spi.spi_wrt = is_wr_state(state_reg);

  always_comb begin
    spi.spi_cmd = 16'h0000;
    case (state_reg)
      INIT_WR, INIT_WT: spi.spi_cmd = INIT_CMDS[idx_reg];
      RD_WR, RD_WT:     spi.spi_cmd = READ_CMDS[idx_reg];
      default:          spi.spi_cmd = 16'h0000;
    endcase
  end

  assign rd_capture   = (state_reg == RD_WT) && spi.spi_done;
  assign last_capture = rd_capture && (idx_reg == 2'd3);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      hold_next[i] = hold_reg[i];
      if (rd_capture && idx_reg == 2'(i))
        hold_next[i] = spi.spi_rd_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        hold_reg[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++)
        hold_reg[i] <= hold_next[i];
    end
  end

  // Outputs load on the edge entering DONE, from the post-capture byte view, so the
  // final AZH byte is already included when vld rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_rt <= 16'h0000;
      AZ      <= 16'h0000;
      vld     <= 1'b0;
    end else begin
      vld <= last_capture;
      if (last_capture) begin
        ptch_rt <= {hold_next[1], hold_next[0]};
        AZ      <= {hold_next[3], hold_next[2]};
      end
    end
  end

endmodule

// File: tb/tb_inertial_read_ctrl.sv
// Scoreboard bench for inertial_read_ctrl with an 8-cycle SPI master model.
module tb_inertial_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_in = 1'b0;
  logic [15:0] ptch_rt, AZ;
  logic        vld;

  inertial_read_ctrl_if spi_if ();

  inertial_read_ctrl #(.PWRUP_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .INT     (int_in),
    .spi     (spi_if.master),
    .ptch_rt (ptch_rt),
    .AZ      (AZ),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cmd_q [$];
  logic [31:0] exp_vld_q [$];
  logic [7:0]  resp [4];

  bit          busy = 1'b0;
  int          cnt = 0, cyc = 0, done_cyc = 0, vld_cyc = 0, last_gap = 0;
  int          vld_cnt = 0, wrt_cnt = 0;
  int          stray_req = 0, stray_served = 0, ext_req = 0, ext_served = 0;
  bit          ext_pend = 1'b0;
  logic [15:0] cur_cmd = 16'h0000;
  logic [15:0] prev_pr = 16'h0000, prev_az = 16'h0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int resp_idx(input logic [15:0] c);
    case (c[15:8])
      8'hA5:   return 1;
      8'hAC:   return 2;
      8'hAD:   return 3;
      default: return 0;
    endcase
  endfunction

  task automatic push_init();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic push_read(input bit with_vld);
    exp_cmd_q.push_back(16'hA400);
    exp_cmd_q.push_back(16'hA500);
    exp_cmd_q.push_back(16'hAC00);
    if (with_vld) begin
      exp_cmd_q.push_back(16'hAD00);
      exp_vld_q.push_back({resp[1], resp[0], resp[3], resp[2]});
    end
  endtask

  task automatic pulse_int(input int len);
    @(posedge clk); #1 int_in = 1'b1;
    repeat (len) @(posedge clk);
    #1 int_in = 1'b0;
  endtask

  task automatic wait_vld(input int target, input int budget);
    int n = 0;
    while (vld_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("vld_wait", 32'(vld_cnt >= target), 32'd1);
  endtask

  task automatic wait_sb_idle(input int budget);
    int n = 0;
    while ((exp_cmd_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_val("sb_drain", 32'(exp_cmd_q.size()), 32'd0);
  endtask

  task automatic check_pwrup(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_val({tag, "_no_wrt"}, 32'(spi_if.spi_wrt), 32'd0);
      if (tag == "pwrup1" && i == 4) int_in = 1'b1;
      if (tag == "pwrup1" && i == 9) int_in = 1'b0;
    end
    @(negedge clk);
    check_val({tag, "_init_start"}, 32'(spi_if.spi_wrt), 32'd1);
  endtask

  // SPI master model plus output monitor; sole driver of the SPI response signals.
  initial begin
    logic [31:0] exp_v;
    spi_if.spi_done    = 1'b0;
    spi_if.spi_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        busy    = 1'b0;
        cur_cmd = 16'h0000;
        prev_pr = 16'h0000;
        prev_az = 16'h0000;
      end else begin
        if (spi_if.spi_done && cur_cmd == 16'hAD00) done_cyc = cyc;
        if (spi_if.spi_wrt) begin
          check_val("wrt_while_busy", 32'(busy), 32'd0);
          check_val("wrt_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
          if (exp_cmd_q.size() != 0)
            check_val("cmd", spi_if.spi_cmd, exp_cmd_q.pop_front());
          if (spi_if.spi_cmd == 16'hA400) last_gap = cyc - vld_cyc;
          busy    = 1'b1;
          cnt     = 8;
          cur_cmd = spi_if.spi_cmd;
          wrt_cnt++;
        end else if (busy) begin
          check_val("cmd_stable", spi_if.spi_cmd, cur_cmd);
        end
        if (vld) begin
          vld_cnt++;
          vld_cyc = cyc;
          check_val("vld_latency", 32'(cyc - done_cyc), 32'd1);
          check_val("vld_expected", 32'(exp_vld_q.size() != 0), 32'd1);
          if (exp_vld_q.size() != 0) begin
            exp_v = exp_vld_q.pop_front();
            check_val("ptch_rt", ptch_rt, exp_v[31:16]);
            check_val("AZ", AZ, exp_v[15:0]);
          end
        end else begin
          check_val("ptch_hold", ptch_rt, prev_pr);
          check_val("az_hold", AZ, prev_az);
        end
        prev_pr = ptch_rt;
        prev_az = AZ;
      end

      @(posedge clk);
      #1;
      spi_if.spi_done = 1'b0;
      if (!rst_n) begin
        busy     = 1'b0;
        ext_pend = 1'b0;
      end else if (ext_pend) begin
        spi_if.spi_done = 1'b1;
        ext_pend        = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy               = 1'b0;
          spi_if.spi_done    = 1'b1;
          spi_if.spi_rd_data = {8'hEE, resp[resp_idx(cur_cmd)]};
          // Stretch this done into the following RD_WR cycle.
          if (ext_served < ext_req && cur_cmd == 16'hA400) begin
            ext_pend = 1'b1;
            ext_served++;
          end
        end
      end else if (stray_served < stray_req) begin
        spi_if.spi_done    = 1'b1;
        spi_if.spi_rd_data = 16'hBEEF;
        stray_served++;
      end
    end
  end

  initial begin
    resp = '{8'h34, 8'h12, 8'h78, 8'hF6};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_wrt", 32'(spi_if.spi_wrt), 32'd0);
    check_val("rst_cmd", spi_if.spi_cmd, 32'h0000);
    check_val("rst_vld", 32'(vld), 32'd0);
    check_val("rst_ptch", ptch_rt, 32'h0000);
    check_val("rst_az", AZ, 32'h0000);

    // Power-up wait (INT pulsed inside it) and init writes.
    push_init();
    @(posedge clk); #1 rst_n = 1'b1;
    check_pwrup("pwrup1");
    wait_sb_idle(400);
    repeat (5) @(posedge clk);
    check_val("no_read_after_pwrup_int", 32'(wrt_cnt), 32'd4);

    // Single read, with a stretched done overlapping RD_WR.
    ext_req++;
    push_read(1'b1);
    pulse_int(3);
    wait_vld(1, 300);
    repeat (5) @(posedge clk);
    check_val("ptch_after_rd1", ptch_rt, 32'h1234);
    check_val("az_after_rd1", AZ, 32'hF678);

    // Stray dones in IDLE.
    stray_req += 3;
    repeat (20) @(posedge clk);
    check_val("idle_stray_no_wrt", 32'(wrt_cnt), 32'd8);

    // INT held through a full read, re-pulsed during the second read.
    resp = '{8'h01, 8'h80, 8'hCD, 8'h0B};
    push_read(1'b1);
    push_read(1'b1);
    @(posedge clk); #1 int_in = 1'b1;
    wait_vld(2, 300);
    repeat (4) @(negedge clk);
    check_val("b2b_gap", 32'(last_gap), 32'd2);
    @(posedge clk); #1 int_in = 1'b0;
    repeat (8) @(posedge clk);
    pulse_int(3);
    wait_vld(3, 300);
    repeat (30) @(posedge clk);
    check_val("reads_per_idle", 32'(wrt_cnt), 32'd16);
    check_val("ptch_after_rd3", ptch_rt, 32'h8001);

    // Reset while waiting on the third read byte.
    resp = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_read(1'b0);
    pulse_int(3);
    begin
      int n = 0;
      while (!(cur_cmd == 16'hAC00 && busy) && n < 300) begin
        @(posedge clk);
        n++;
      end
      check_val("reached_rd3", 32'(cur_cmd), 32'hAC00);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_wrt", 32'(spi_if.spi_wrt), 32'd0);
    check_val("arst_cmd", spi_if.spi_cmd, 32'h0000);
    check_val("arst_vld", 32'(vld), 32'd0);
    check_val("arst_ptch", ptch_rt, 32'h0000);
    check_val("arst_az", AZ, 32'h0000);
    repeat (3) @(posedge clk);
    push_init();
    #1 rst_n = 1'b1;
    check_pwrup("pwrup2");
    wait_sb_idle(400);
    repeat (5) @(posedge clk);
    check_val("ptch_after_reinit", ptch_rt, 32'h0000);

    resp = '{8'h55, 8'h66, 8'h77, 8'h88};
    push_read(1'b1);
    pulse_int(3);
    wait_vld(4, 300);
    repeat (20) @(posedge clk);
    check_val("sb_cmd_left", 32'(exp_cmd_q.size()), 32'd0);
    check_val("sb_vld_left", 32'(exp_vld_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
